// File: rtl/vedic_col_sched_if.sv
// rtl/vedic_col_sched_if.sv - start/operand request and busy/done/product response bundle
interface vedic_col_sched_if #(parameter int W = 4);
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/vedic_col_sched.sv
// rtl/vedic_col_sched.sv - sequential vertical-crosswise multiplier, one column-sum per clock
module vedic_col_sched #(
  parameter int W = 4
) (
  input  logic              clk,
  input  logic              rst,
  vedic_col_sched_if.slave  bus
);
  localparam int SW  = $clog2(2 * W);
  localparam int CW  = SW - 1;
  localparam int CLW = $clog2(2 * W);

  typedef enum logic [1:0] {S_IDLE, S_COL, S_FLUSH} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [CW-1:0]  r_carry;
  logic [CLW-1:0] r_col;
  logic [2*W-1:0] r_product;
  logic           r_done;
  logic [SW-1:0]  w_sum;
  logic           w_accept;
  logic           w_busy;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_COL;
      S_COL:   if (r_col == CLW'(2 * W - 2)) w_next = S_FLUSH;
      S_FLUSH: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state != S_IDLE);
    w_accept = (r_state == S_IDLE) && bus.start;
  end

  // Column col collects every a[i]&b[j] with i+j == col, plus the carry from the previous column.
  always_comb begin
    w_sum = {1'b0, r_carry};
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        if (i + j == int'(r_col)) w_sum = w_sum + SW'(r_a[i] & r_b[j]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_carry   <= '0;
      r_col     <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == S_FLUSH);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a       <= bus.a;
            r_b       <= bus.b;
            r_carry   <= '0;
            r_col     <= '0;
            r_product <= '0;
          end
        end
        S_COL: begin
          r_product[r_col] <= w_sum[0];
          r_carry          <= w_sum[SW-1:1];
          r_col            <= r_col + CLW'(1);
        end
        S_FLUSH: r_product[2*W-1] <= r_carry[0];
        default: ;
      endcase
    end
  end

  // The final carry feeds a single product bit, so anything above bit 0 would be lost.
  always @(posedge clk) begin
    if (!rst && r_state == S_FLUSH) assert ((r_carry >> 1) == '0);
  end

  assign bus.busy    = w_busy;
  assign bus.done    = r_done;
  assign bus.product = r_product;
endmodule

// File: tb/tb_vedic_col_sched.sv
// tb/tb_vedic_col_sched.sv - scoreboard bench for vedic_col_sched at W=4 and W=8
module tb_vedic_col_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0]  exp4[$];
  logic [15:0] exp8[$];

  vedic_col_sched_if #(.W(4)) bus4();
  vedic_col_sched_if #(.W(8)) bus8();

  vedic_col_sched #(.W(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  vedic_col_sched #(.W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitors: pop at every done, and check latency / pulse rules.
  int  busy_cnt4 = 0;
  logic prev_done4 = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus4.done) begin
        if (exp4.size() == 0) chk("w4_unexpected_done", 1, 0);
        else chk("w4_product", bus4.product, exp4.pop_front());
        chk("w4_latency", busy_cnt4, 8);
        chk("w4_done_busy_overlap", bus4.busy, 0);
        chk("w4_done_double", prev_done4, 0);
      end
      if (bus4.busy) busy_cnt4++;
      else busy_cnt4 = 0;
    end else busy_cnt4 = 0;
    prev_done4 = bus4.done;
  end

  int  busy_cnt8 = 0;
  logic prev_done8 = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus8.done) begin
        if (exp8.size() == 0) chk("w8_unexpected_done", 1, 0);
        else chk("w8_product", bus8.product, exp8.pop_front());
        chk("w8_latency", busy_cnt8, 16);
        chk("w8_done_busy_overlap", bus8.busy, 0);
        chk("w8_done_double", prev_done8, 0);
      end
      if (bus8.busy) busy_cnt8++;
      else busy_cnt8 = 0;
    end else busy_cnt8 = 0;
    prev_done8 = bus8.done;
  end

  task automatic wait_idle4();
    int n = 0;
    @(negedge clk);
    while (bus4.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("w4_idle_timeout", 1, 0);
  endtask

  task automatic issue4(input logic [3:0] a, input logic [3:0] b);
    wait_idle4();
    bus4.start = 1'b1;
    bus4.a = a;
    bus4.b = b;
    @(posedge clk);
    exp4.push_back(8'(a * b));
    @(negedge clk);
    bus4.start = 1'b0;
  endtask

  task automatic drain4();
    int n = 0;
    while (exp4.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("w4_done_timeout", 1, 0);
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (bus8.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("w8_idle_timeout", 1, 0);
    bus8.start = 1'b1;
    bus8.a = a;
    bus8.b = b;
    @(posedge clk);
    exp8.push_back(16'(a * b));
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", bus4.busy, 0);
    chk("reset_done", bus4.done, 0);
    chk("reset_product", bus4.product, 0);

    // Directed products
    issue4(4'd15, 4'd15); drain4();
    issue4(4'd0, 4'd9);   drain4();
    issue4(4'd1, 4'd1);   drain4();
    issue4(4'd8, 4'd8);   drain4();

    // start pulse while busy is ignored
    issue4(4'd5, 4'd3);
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = 4'd7; bus4.b = 4'd7;
    @(negedge clk);
    bus4.start = 1'b0;
    drain4();

    // Reset aborts an operation in flight
    issue4(4'd12, 4'd11);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp4.delete();
    chk("abort_busy", bus4.busy, 0);
    chk("abort_done", bus4.done, 0);
    chk("abort_product", bus4.product, 0);
    issue4(4'd12, 4'd11); drain4();

    // start held across the done cycle: back-to-back with no bubble
    wait_idle4();
    bus4.start = 1'b1; bus4.a = 4'd6; bus4.b = 4'd9;
    @(posedge clk);
    exp4.push_back(8'd54);
    @(negedge clk);
    bus4.a = 4'd10; bus4.b = 4'd13;
    n = 0;
    while (!bus4.done && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("b2b_done_timeout", 1, 0);
    @(posedge clk);
    exp4.push_back(8'd130);
    @(negedge clk);
    chk("b2b_busy_after_done", bus4.busy, 1);
    bus4.start = 1'b0;
    drain4();

    // Exhaustive W=4
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue4(4'(a), 4'(b));
      end
    end
    drain4();

    // W=8 corners plus random pairs
    issue8(8'd255, 8'd255);
    issue8(8'd0, 8'd200);
    issue8(8'd128, 8'd2);
    for (int k = 0; k < 40; k++) begin
      issue8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    n = 0;
    while (exp8.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("w8_done_timeout", 1, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
